spi_txn_arbiter: RTL and testbench

- Shares one spi_controller among REQ_CNT requesters (cores, DMA, debug) with round-robin arbitration.
- Latches the winner's command, loads the controller's data register, then pulses start.
- Waits for end-of-transaction or timeout, then returns read data and a status to the winner.
- Sits between the requester fabric and the spi_controller's core-side ports.

---
 rtl/spi_txn_arbiter.sv | 177 +++++++++++++++++
 tb/tb_spi_txn_arbiter.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter that shares one spi_controller among REQ_CNT requesters.
// The winner's command is latched, loaded into the controller, and started. The
// arbiter then waits for end-of-transaction or a timeout and returns read data
// and a status to the winner.
module spi_txn_arbiter #(
    parameter int unsigned REQ_CNT        = 4,
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned PERI_CNT       = 4,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    localparam int unsigned PIW = (PERI_CNT > 1) ? $clog2(PERI_CNT) : 1,
    localparam int unsigned GIW = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1
) (
    input  logic                          clk,
    input  logic                          sync_rst,
    input  logic                          clk_en,
    input  logic [REQ_CNT-1:0]            req_valid,
    input  logic [REQ_CNT*PIW-1:0]        req_peri_idx,
    input  logic [REQ_CNT*2-1:0]          req_spi_mode,
    input  logic [REQ_CNT*3-1:0]          req_byte_sel,
    input  logic [REQ_CNT*DATA_WIDTH-1:0] req_wr_data,
    output logic [REQ_CNT-1:0]            req_ready,
    output logic [REQ_CNT-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rd_data,
    output logic [1:0]                    rsp_status,
    output logic                          spi_wr_en,
    output logic [DATA_WIDTH-1:0]         spi_wr_data,
    output logic [1:0]                    spi_mode,
    output logic [2:0]                    spi_byte_sel,
    output logic [PERI_CNT-1:0]           spi_chip_sel_one_cold,
    output logic                          spi_start_txn,
    input  logic                          spi_end_txn,
    input  logic [DATA_WIDTH-1:0]         spi_rd_data,
    output logic                          busy,
    output logic [GIW-1:0]                grant_id
);

    localparam int unsigned TCW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned IDX_SPAN = 1 << PIW;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StLoad  = 3'd1;
    localparam logic [2:0] StStart = 3'd2;
    localparam logic [2:0] StWait  = 3'd3;
    localparam logic [2:0] StResp  = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [GIW-1:0]        ptr_q;
    logic [GIW-1:0]        grant_q;
    logic [PIW-1:0]        idx_q;
    logic [1:0]            mode_q;
    logic [2:0]            bsel_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            status_q;
    logic [TCW-1:0]        tmo_q;

    logic                  any_valid;
    logic [GIW-1:0]        winner;
    logic [PIW-1:0]        win_idx;
    logic                  win_bad;
    logic [IDX_SPAN-1:0]   idx_ok;
    logic                  tmo_done;
    logic                  en_ok;

    // Strobes are suppressed while stalled or in reset so each lasts one enabled cycle.
    assign en_ok    = clk_en && !sync_rst;
    assign tmo_done = (tmo_q == TCW'(TIMEOUT_CYCLES - 1));
    assign win_idx  = req_peri_idx[winner*PIW +: PIW];
    assign win_bad  = !idx_ok[win_idx];

    // Index values that decode to a real chip select.
    for (genvar g = 0; g < IDX_SPAN; g++) begin : g_idx_ok
        assign idx_ok[g] = (g < PERI_CNT);
    end

    // Round-robin search starting just after the last winner, with wrap-around.
    always_comb begin
        any_valid = 1'b0;
        winner    = '0;
        for (int k = 1; k <= int'(REQ_CNT); k++) begin
            if (!any_valid && req_valid[GIW'((int'(ptr_q) + k) % int'(REQ_CNT))]) begin
                any_valid = 1'b1;
                winner    = GIW'((int'(ptr_q) + k) % int'(REQ_CNT));
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (any_valid) state_d = win_bad ? StResp : StLoad;
            StLoad:  state_d = StStart;
            StStart: state_d = StWait;
            StWait:  if (spi_end_txn || tmo_done) state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State, latched command, timeout counter and response registers.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state_q  <= StIdle;
            ptr_q    <= GIW'(REQ_CNT - 1);
            grant_q  <= '0;
            idx_q    <= '0;
            mode_q   <= '0;
            bsel_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            status_q <= 2'b00;
            tmo_q    <= '0;
        end else if (clk_en) begin
            state_q <= state_d;
            case (state_q)
                StIdle: begin
                    if (any_valid) begin
                        idx_q   <= win_idx;
                        mode_q  <= req_spi_mode[winner*2 +: 2];
                        bsel_q  <= req_byte_sel[winner*3 +: 3];
                        wdata_q <= req_wr_data[winner*DATA_WIDTH +: DATA_WIDTH];
                        grant_q <= winner;
                        ptr_q   <= winner;
                        if (win_bad) begin
                            rdata_q  <= '0;
                            status_q <= 2'b10;
                        end
                    end
                end
                StStart: tmo_q <= '0;
                StWait: begin
                    // end_txn takes priority over a timeout expiring in the same cycle
                    if (spi_end_txn) begin
                        rdata_q  <= spi_rd_data;
                        status_q <= 2'b00;
                    end else if (tmo_done) begin
                        rdata_q  <= '0;
                        status_q <= 2'b01;
                    end else begin
                        tmo_q <= tmo_q + TCW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // One-hot accept and response strobes.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        if (en_ok && state_q == StIdle && any_valid) req_ready[winner] = 1'b1;
        if (en_ok && state_q == StResp) rsp_valid[grant_q] = 1'b1;
    end

    // Chip select is driven low only through START and WAIT.
    always_comb begin
        spi_chip_sel_one_cold = '1;
        if (state_q == StStart || state_q == StWait) begin
            for (int p = 0; p < int'(PERI_CNT); p++) begin
                if (idx_q == PIW'(p)) spi_chip_sel_one_cold[p] = 1'b0;
            end
        end
    end

    assign spi_wr_en     = en_ok && (state_q == StLoad);
    assign spi_start_txn = en_ok && (state_q == StStart);
    assign spi_wr_data   = wdata_q;
    assign spi_mode      = mode_q;
    assign spi_byte_sel  = bsel_q;
    assign rsp_rd_data   = rdata_q;
    assign rsp_status    = status_q;
    assign busy          = (state_q != StIdle);
    assign grant_id      = grant_q;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Bench for spi_txn_arbiter: a transaction-age model checks dut_a every cycle,
// directed sequences pin literal expectations; dut_b covers a bad peripheral index.
module tb_spi_txn_arbiter;

    logic         clk = 1'b0;
    logic         sync_rst = 1'b1;
    logic         clk_en = 1'b1;
    logic [3:0]   req_valid = '0;
    logic [3:0]   req_valid_b = '0;
    logic [7:0]   req_peri_idx = '0;
    logic [7:0]   req_spi_mode = '0;
    logic [11:0]  req_byte_sel = '0;
    logic [255:0] req_wr_data = '0;
    logic         spi_end_txn;
    logic [63:0]  spi_rd_data = '0;

    logic [3:0]  ready_a, rsp_valid_a, cs_a;
    logic [63:0] rsp_data_a, wr_data_a;
    logic [1:0]  status_a, mode_a, grant_a;
    logic [2:0]  bsel_a;
    logic        wr_en_a, start_a, busy_a;

    logic [3:0]  ready_b, rsp_valid_b;
    logic [63:0] rsp_data_b, wr_data_b;
    logic [1:0]  status_b, mode_b, grant_b;
    logic [2:0]  bsel_b, cs_b;
    logic        wr_en_b, start_b, busy_b;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_on   = 1'b0;
    int lat      = 0;

    always #5 clk = ~clk;

    spi_txn_arbiter #(
        .REQ_CNT(4), .DATA_WIDTH(64), .PERI_CNT(4), .TIMEOUT_CYCLES(16)
    ) dut_a (
        .clk(clk), .sync_rst(sync_rst), .clk_en(clk_en),
        .req_valid(req_valid), .req_peri_idx(req_peri_idx), .req_spi_mode(req_spi_mode),
        .req_byte_sel(req_byte_sel), .req_wr_data(req_wr_data), .req_ready(ready_a),
        .rsp_valid(rsp_valid_a), .rsp_rd_data(rsp_data_a), .rsp_status(status_a),
        .spi_wr_en(wr_en_a), .spi_wr_data(wr_data_a), .spi_mode(mode_a),
        .spi_byte_sel(bsel_a), .spi_chip_sel_one_cold(cs_a), .spi_start_txn(start_a),
        .spi_end_txn(spi_end_txn), .spi_rd_data(spi_rd_data), .busy(busy_a),
        .grant_id(grant_a)
    );

    spi_txn_arbiter #(
        .REQ_CNT(4), .DATA_WIDTH(64), .PERI_CNT(3), .TIMEOUT_CYCLES(16)
    ) dut_b (
        .clk(clk), .sync_rst(sync_rst), .clk_en(clk_en),
        .req_valid(req_valid_b), .req_peri_idx(req_peri_idx), .req_spi_mode(req_spi_mode),
        .req_byte_sel(req_byte_sel), .req_wr_data(req_wr_data), .req_ready(ready_b),
        .rsp_valid(rsp_valid_b), .rsp_rd_data(rsp_data_b), .rsp_status(status_b),
        .spi_wr_en(wr_en_b), .spi_wr_data(wr_data_b), .spi_mode(mode_b),
        .spi_byte_sel(bsel_b), .spi_chip_sel_one_cold(cs_b), .spi_start_txn(start_b),
        .spi_end_txn(spi_end_txn), .spi_rd_data(spi_rd_data), .busy(busy_b),
        .grant_id(grant_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model of dut_a ----------------
    // Tracks the age of the active transaction in enabled cycles since accept:
    // age 1 = data load, age 2 = start, age >= 3 = waiting, resp_age = response.
    int          m_ptr, m_grant, m_age, m_resp_age, m_idx;
    bit          m_busy, m_bad;
    logic [1:0]  m_mode, m_stat;
    logic [2:0]  m_bsel;
    logic [63:0] m_wdata, m_rdata;
    bit          e_any, e_resp, e_en, e_wr, e_start;
    int          e_win;
    logic [3:0]  e_ready, e_rv, e_cs;

    initial begin : model
        forever begin
            @(negedge clk);
            e_any = 1'b0;
            e_win = 0;
            for (int k = 1; k <= 4; k++) begin
                if (!e_any && req_valid[(m_ptr + k) % 4]) begin
                    e_any = 1'b1;
                    e_win = (m_ptr + k) % 4;
                end
            end
            e_en    = clk_en && !sync_rst;
            e_resp  = m_busy && (m_age == m_resp_age);
            e_ready = (!m_busy && e_any && e_en) ? 4'(1 << e_win) : 4'h0;
            e_wr    = m_busy && !m_bad && (m_age == 1) && e_en;
            e_start = m_busy && !m_bad && (m_age == 2) && e_en;
            e_cs    = (m_busy && !m_bad && m_age >= 2 && !e_resp) ? ~(4'(1 << m_idx)) : 4'hF;
            e_rv    = (e_resp && e_en) ? 4'(1 << m_grant) : 4'h0;
            if (chk_on) begin
                check("m_ready", ready_a, e_ready);
                check("m_busy", busy_a, m_busy);
                check("m_grant", grant_a, m_grant[1:0]);
                check("m_wr_en", wr_en_a, e_wr);
                check("m_wr_data", wr_data_a, m_wdata);
                check("m_mode", mode_a, m_mode);
                check("m_bsel", bsel_a, m_bsel);
                check("m_start", start_a, e_start);
                check("m_cs", cs_a, e_cs);
                check("m_rsp_valid", rsp_valid_a, e_rv);
                check("m_rsp_data", rsp_data_a, m_rdata);
                check("m_rsp_status", status_a, m_stat);
            end
            if (sync_rst) begin
                m_busy = 0; m_ptr = 3; m_grant = 0; m_age = 0; m_resp_age = -1;
                m_idx = 0; m_bad = 0; m_mode = 0; m_bsel = 0; m_wdata = 0;
                m_rdata = 0; m_stat = 0;
            end else if (clk_en) begin
                if (!m_busy) begin
                    if (e_any) begin
                        m_busy  = 1; m_age = 1;
                        m_idx   = int'(req_peri_idx[e_win*2 +: 2]);
                        m_mode  = req_spi_mode[e_win*2 +: 2];
                        m_bsel  = req_byte_sel[e_win*3 +: 3];
                        m_wdata = req_wr_data[e_win*64 +: 64];
                        m_grant = e_win; m_ptr = e_win;
                        m_bad   = (m_idx >= 4);
                        m_resp_age = -1;
                        if (m_bad) begin m_resp_age = 1; m_rdata = 0; m_stat = 2'b10; end
                    end
                end else if (e_resp) begin
                    m_busy = 0;
                end else begin
                    if (!m_bad && m_age >= 3) begin
                        if (spi_end_txn) begin
                            m_resp_age = m_age + 1; m_rdata = spi_rd_data; m_stat = 2'b00;
                        end else if (m_age - 2 == 16) begin
                            m_resp_age = m_age + 1; m_rdata = 0; m_stat = 2'b01;
                        end
                    end
                    m_age++;
                end
            end
        end
    end

    // Controller stand-in: pulses end_txn 'lat' cycles after each start (0 = never).
    initial begin : responder
        int cnt;
        bit s;
        cnt = 0;
        spi_end_txn = 1'b0;
        forever begin
            @(negedge clk);
            s = start_a;
            @(posedge clk);
            #1;
            spi_end_txn = 1'b0;
            if (lat == 0) cnt = 0;
            else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) spi_end_txn = 1'b1;
            end
            if (s && lat > 1) cnt = lat - 1;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [1:0] idx, input logic [1:0] mode,
                           input logic [2:0] bsel, input logic [63:0] d);
        req_peri_idx[i*2 +: 2]  = idx;
        req_spi_mode[i*2 +: 2]  = mode;
        req_byte_sel[i*3 +: 3]  = bsel;
        req_wr_data[i*64 +: 64] = d;
    endtask

    // sel: 0 ready_a, 1 start_a, 2 rsp_valid_a, 3 ready_b, other rsp_valid_b.
    // n = number of negedges until the event is seen.
    task automatic wait_evt(input int sel, input int bound, input string name, output int n);
        bit hit;
        hit = 1'b0;
        n = 0;
        while (!hit && n < bound) begin
            @(negedge clk);
            n++;
            case (sel)
                0: hit = |ready_a;
                1: hit = start_a;
                2: hit = |rsp_valid_a;
                3: hit = |ready_b;
                default: hit = |rsp_valid_b;
            endcase
        end
        if (!hit) begin
            n_checks++;
            n_err++;
            $display("FAIL %s: no event within %0d cycles", name, bound);
            n = -1;
        end
    endtask

    task automatic do_reset();
        step();
        sync_rst = 1'b1;
        step();
        sync_rst = 1'b0;
    endtask

    function automatic int oh2i(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    int exp_rr[10] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 2};

    // ---------------- directed sequence ----------------
    initial begin : stim
        int n;
        int wr_cnt;
        repeat (3) step();
        sync_rst = 1'b0;
        chk_on   = 1'b1;
        @(negedge clk);
        check("rst_cs", cs_a, 4'hF);
        check("rst_busy", busy_a, 1'b0);
        check("rst_grant", grant_a, 2'd0);
        check("rst_status", status_a, 2'b00);
        check("rst_cs_b", cs_b, 3'b111);

        // Single request
        step();
        lat = 10;
        spi_rd_data = 64'h55AA;
        set_req(2, 2'd1, 2'b01, 3'd7, 64'hDEADBEEF_01234567);
        req_valid = 4'b0100;
        wait_evt(0, 20, "single_accept", n);
        check("single_ready", ready_a, 4'b0100);
        step();
        req_valid = 4'b0000;
        @(negedge clk);
        check("single_wr_en", wr_en_a, 1'b1);
        check("single_wr_data", wr_data_a, 64'hDEADBEEF_01234567);
        @(negedge clk);
        check("single_start", start_a, 1'b1);
        check("single_cs", cs_a, 4'b1101);
        check("single_mode", mode_a, 2'b01);
        check("single_bsel", bsel_a, 3'd7);
        wait_evt(2, 30, "single_rsp", n);
        check("single_rsp_lat", n, 11);
        check("single_rsp_valid", rsp_valid_a, 4'b0100);
        check("single_rsp_data", rsp_data_a, 64'h55AA);
        check("single_rsp_status", status_a, 2'b00);
        check("single_cs_idle", cs_a, 4'hF);

        // Round robin with requester 1 dropping out after its second grant
        do_reset();
        lat = 3;
        for (int i = 0; i < 4; i++)
            set_req(i, 2'(i), 2'(i), 3'(i), 64'hA0A0_0000_0000_0000 + 64'(i));
        req_valid = 4'hF;
        for (int g = 0; g < 10; g++) begin
            wait_evt(0, 40, "rr_accept", n);
            check("rr_grant", oh2i(ready_a), exp_rr[g]);
            if (g == 5) begin
                step();
                req_valid[1] = 1'b0;
            end
        end
        step();
        req_valid = 4'h0;
        wait_evt(2, 40, "rr_last_rsp", n);

        // Timeout
        step();
        lat = 0;
        spi_rd_data = 64'hFFFF;
        set_req(3, 2'd2, 2'b10, 3'd3, 64'h1111);
        req_valid = 4'b1000;
        wait_evt(0, 20, "tmo_accept", n);
        check("tmo_ready", ready_a, 4'b1000);
        step();
        req_valid = 4'b0000;
        wait_evt(1, 10, "tmo_start", n);
        wait_evt(2, 40, "tmo_rsp", n);
        check("tmo_rsp_lat", n, 17);
        check("tmo_rsp_valid", rsp_valid_a, 4'b1000);
        check("tmo_rsp_data", rsp_data_a, 64'h0);
        check("tmo_rsp_status", status_a, 2'b01);
        check("tmo_cs", cs_a, 4'hF);

        // end_txn on the cycle the timeout expires
        step();
        lat = 16;
        spi_rd_data = 64'h1234_5678_9ABC_DEF0;
        set_req(0, 2'd0, 2'b11, 3'd1, 64'h2222);
        req_valid = 4'b0001;
        wait_evt(0, 20, "coin_accept", n);
        step();
        req_valid = 4'b0000;
        wait_evt(1, 10, "coin_start", n);
        wait_evt(2, 40, "coin_rsp", n);
        check("coin_rsp_lat", n, 17);
        check("coin_rsp_status", status_a, 2'b00);
        check("coin_rsp_data", rsp_data_a, 64'h1234_5678_9ABC_DEF0);

        // Bad peripheral index on the 3-peripheral instance
        step();
        set_req(0, 2'd3, 2'b00, 3'd0, 64'h3333);
        req_valid_b = 4'b0001;
        wait_evt(3, 20, "bad_accept", n);
        check("bad_ready", ready_b, 4'b0001);
        check("bad_cs_accept", cs_b, 3'b111);
        step();
        req_valid_b = 4'b0000;
        @(negedge clk);
        check("bad_rsp_valid", rsp_valid_b, 4'b0001);
        check("bad_rsp_status", status_b, 2'b10);
        check("bad_wr_en", wr_en_b, 1'b0);
        check("bad_start", start_b, 1'b0);
        check("bad_cs", cs_b, 3'b111);
        @(negedge clk);
        check("bad_idle", busy_b, 1'b0);

        // Reset in the middle of WAIT
        step();
        lat = 0;
        set_req(2, 2'd3, 2'b01, 3'd2, 64'h4444);
        req_valid = 4'b0100;
        wait_evt(0, 20, "rst_accept", n);
        step();
        req_valid = 4'b0000;
        wait_evt(1, 10, "rst_start", n);
        repeat (4) step();
        sync_rst = 1'b1;
        req_valid = 4'b1001;
        @(negedge clk);
        check("rst_mid_rsp", rsp_valid_a, 4'b0000);
        step();
        sync_rst = 1'b0;
        lat = 4;
        @(negedge clk);
        check("rst_mid_busy", busy_a, 1'b0);
        check("rst_mid_cs", cs_a, 4'hF);
        check("rst_mid_rsp2", rsp_valid_a, 4'b0000);
        check("rst_mid_prio", ready_a, 4'b0001);
        step();
        req_valid = 4'b0000;
        wait_evt(2, 40, "rst_after_rsp", n);

        // clk_en dropped for 5 cycles during LOAD
        step();
        lat = 3;
        req_valid = 4'b0010;
        wait_evt(0, 20, "stall_accept", n);
        step();
        clk_en = 1'b0;
        req_valid = 4'b0000;
        wr_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (wr_en_a) wr_cnt++;
            step();
            if (i == 4) clk_en = 1'b1;
        end
        @(negedge clk);
        check("stall_wr_during", wr_cnt, 0);
        check("stall_wr_after", wr_en_a, 1'b1);
        wait_evt(2, 40, "stall_rsp", n);
        check("stall_rsp_valid", rsp_valid_a, 4'b0010);

        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
